seq_pattern_detector: RTL and testbench
=======================================

Name: seq_pattern_detector

Overview:
- Parametrised serial pattern detector: successor to the fixed 010110 detector.
- Recognises a runtime-programmable bit pattern, 1..MAX_LEN bits long, in a serial bit stream qualified by in_valid.
- Selectable overlapping or non-overlapping detection, plus a saturating match counter.
- Sits between a serial input front end and a status/interrupt register block.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (>=2).
- CNT_W, 8: match counter width.
- RST_PATTERN, 8'b0001_0110: pattern after reset, right-aligned.
- RST_LEN, 6: pattern length after reset (reset default detects 010110).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  x is sampled only when high.
- x  input  1  serial data bit.
- cfg_load  input  1  one-cycle strobe: load cfg_pattern/cfg_len/cfg_overlap.
- cfg_pattern  input  MAX_LEN  pattern. Bit [cfg_len-1] is received first; bit [0] is received last.
- cfg_len  input  $clog2(MAX_LEN+1)  pattern length.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  input  1  synchronous clear of match_count.
- z  output  1  registered one-cycle match pulse.
- state  output  2  0 = FILL, 1 = ARMED, 2 = HIT.
- fill  output  $clog2(MAX_LEN+1)  valid history bits, saturating at the active length.
- match_count  output  CNT_W  saturating match count.
- cfg_err  output  1  one-cycle pulse when a cfg_load is rejected.

Behaviour:
- Reset (reset low, asynchronous), all registers:
  - history = 0, fill = 0, state = FILL.
  - z = 0, match_count = 0, cfg_err = 0.
  - pattern = RST_PATTERN, len = RST_LEN, overlap = 1.
- Bit acceptance (in_valid=1 at a rising edge):
  - history shifts left, x enters bit 0.
  - fill increments, saturating at len.
- Match condition, combinational on the post-shift values: new fill == len AND history[len-1:0] == pattern[len-1:0]. Bits above len are ignored.
- z timing: z is high in the cycle after the edge that sampled the final pattern bit, for exactly one cycle, then returns to 0. There is no combinational path from x to z.
- After a match:
  - overlap=1: fill stays at len, so the next bit can complete another match.
  - overlap=0: fill resets to 0; the next match needs len fresh bits.
- in_valid=0: no state change except that z/HIT falls back after its single cycle.
- State machine:
  - FILL while fill < len. FILL -> ARMED when fill reaches len without a match.
  - Any state -> HIT on a match (held one cycle, coincident with z).
  - HIT -> ARMED when overlap=1; HIT -> FILL when overlap=0.
  - Unreachable encoding 3 -> FILL.
- cfg_load, accepted when 1 <= cfg_len <= MAX_LEN:
  - registers the new config and clears history/fill; state = FILL.
  - match_count is kept.
  - cfg_load and in_valid in the same cycle: config wins and that bit is discarded.
- cfg_load rejected when cfg_len == 0 or cfg_len > MAX_LEN: config and history are unchanged, and cfg_err pulses for one cycle.
- match_count:
  - increments by 1 per match and saturates at 2^CNT_W-1; no wrap.
  - cnt_clr with a match in the same cycle: result is 1.
  - cnt_clr alone: result is 0.
- len == 1: every accepted bit equal to pattern[0] produces a match.
  - With overlap=0, fill toggles 0 -> 1 -> 0 across each match.
- Reset asserted mid-sequence: partial progress is discarded immediately, and z drops asynchronously.

Decomposition:
- Shared package seq_det_pkg:
  - state encodings ST_FILL/ST_ARMED/ST_HIT.
  - default pattern constant 6'b010110 and length constant 6.
- One natural sub-module: sat_counter (CNT_W-wide saturating counter with sync clear and increment). It is reusable by other status blocks.
- Shifter, compare and FSM stay in the top.

Test Plan:
- Reset defaults, stream 0,1,0,1,1,0 with in_valid=1: z=1 only in the cycle after the 6th bit; match_count=1; state=HIT, then ARMED.
- Overlap with len=3, pattern 101, overlap=1, stream 1,0,1,0,1: z pulses after bits 3 and 5; match_count=2. Same stream with overlap=0: single pulse after bit 3; match_count=1.
- Gapped valid: reset pattern sent with in_valid low for 3 cycles between bits 2 and 3: still exactly one z pulse, after the final valid bit; fill holds during the gaps.
- Config edges:
  - cfg_load with cfg_len=0: cfg_err=1 for one cycle; pattern unchanged; 010110 still detected.
  - cfg_load with cfg_len=MAX_LEN, pattern 8'hFF, then eight 1s: z after the 8th.
  - cfg_load coincident with in_valid: that bit ignored; fill=0.
- Counter saturation with CNT_W=2, len=1, pattern 1: five consecutive 1s give match_count 1,2,3,3,3. cnt_clr together with a match gives 1.
- Reset mid-operation: assert reset after 5 bits of 01011 → z=0, fill=0, state=FILL at once. After release, a final 0 alone gives no match; a full 010110 is required.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector family: FSM encoding and
// the legacy 010110 reset pattern.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HIT   = 2'd2
    } det_state_t;

    localparam logic [5:0]  DEF_PATTERN = 6'b010110;
    localparam int unsigned DEF_LEN     = 6;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment leaves the count at one.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector with overlap control, a
// registered match pulse and a saturating match counter.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned          MAX_LEN     = 8,
    parameter int unsigned          CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]   RST_PATTERN = MAX_LEN'(DEF_PATTERN),
    parameter int unsigned          RST_LEN     = DEF_LEN,
    localparam int unsigned         LW          = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               x,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               z,
    output logic [1:0]         state,
    output logic [LW-1:0]      fill,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    localparam logic [MAX_LEN-1:0] ONES = '1;

    det_state_t         state_r, state_nxt;
    logic [MAX_LEN-2:0] hist_r, hist_nxt;
    logic [MAX_LEN-1:0] pat_r;
    logic [LW-1:0]      len_r;
    logic               ov_r;
    logic [LW-1:0]      fill_r, fill_nxt;
    logic               z_r;
    logic               err_r;

    logic               cfg_ok, cfg_acc, cfg_rej, take, hit;
    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] len_mask;
    logic [LW-1:0]      fill_inc;

    // A config strobe owns its cycle, so any bit presented alongside it is dropped.
    assign cfg_ok  = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
    assign cfg_acc = cfg_load && cfg_ok;
    assign cfg_rej = cfg_load && !cfg_ok;
    assign take    = in_valid && !cfg_load;

    // Datapath: the stored history is one bit short because the compare
    // always works on the post-shift view, where the new bit completes it.
    always_comb begin
        hist_shift = {hist_r, x};
        len_mask   = ~(ONES << len_r);
        fill_inc   = (fill_r >= len_r) ? len_r : fill_r + LW'(1);
        hit        = take && (fill_inc == len_r)
                     && (((hist_shift ^ pat_r) & len_mask) == '0);
        hist_nxt   = hist_r;
        fill_nxt   = fill_r;
        if (cfg_acc) begin
            hist_nxt = '0;
            fill_nxt = '0;
        end else if (take) begin
            hist_nxt = hist_shift[MAX_LEN-2:0];
            fill_nxt = (hit && !ov_r) ? '0 : fill_inc;
        end
    end

    always_comb begin
        state_nxt = state_r;
        if (cfg_acc) begin
            state_nxt = ST_FILL;
        end else if (hit) begin
            state_nxt = ST_HIT;
        end else if (take) begin
            state_nxt = (fill_nxt == len_r) ? ST_ARMED : ST_FILL;
        end else begin
            case (state_r)
                ST_HIT:   state_nxt = ov_r ? ST_ARMED : ST_FILL;
                ST_ARMED: state_nxt = ST_ARMED;
                ST_FILL:  state_nxt = ST_FILL;
                default:  state_nxt = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_r <= '0;
            fill_r <= '0;
            pat_r  <= RST_PATTERN;
            len_r  <= LW'(RST_LEN);
            ov_r   <= 1'b1;
            z_r    <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            hist_r <= hist_nxt;
            fill_r <= fill_nxt;
            z_r    <= hit;
            err_r  <= cfg_rej;
            if (cfg_acc) begin
                pat_r <= cfg_pattern;
                len_r <= cfg_len;
                ov_r  <= cfg_overlap;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (hit),
        .count (match_count)
    );

    assign z       = z_r;
    assign state   = state_r;
    assign fill    = fill_r;
    assign cfg_err = err_r;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a queue-based behavioural model of the detector.
module tb_seq_pattern_detector;

    localparam int ML = 8;
    localparam int CW = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          x = 1'b0;
    logic          cfg_load = 1'b0;
    logic [ML-1:0] cfg_pattern = '0;
    logic [3:0]    cfg_len = '0;
    logic          cfg_overlap = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          z;
    logic [1:0]    state;
    logic [3:0]    fill;
    logic [CW-1:0] match_count;
    logic          cfg_err;

    seq_pattern_detector #(
        .MAX_LEN (ML),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .x           (x),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .z           (z),
        .state       (state),
        .fill        (fill),
        .match_count (match_count),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    int    n_chk  = 0;
    int    n_pass = 0;
    string phase  = "init";

    // Reference model: raw accepted bits since the last history clear.
    bit          m_hist[$];
    bit [ML-1:0] m_pat;
    int          m_len, m_fill, m_cnt, m_state;
    bit          m_ov, m_z, m_err;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s/%s: got %0d expected %0d", phase, tag, obs, exp);
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_pat = 8'b0001_0110; m_len = 6; m_ov = 1'b1;
        m_fill = 0; m_cnt = 0; m_z = 1'b0; m_err = 1'b0; m_state = 0;
    endtask

    function automatic bit tail_match();
        int sz = m_hist.size();
        if (sz < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++)
            if (m_hist[sz - m_len + i] != m_pat[m_len - 1 - i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input bit v, input bit xb, input bit cl, input bit [ML-1:0] cp,
                              input int clen, input bit cov, input bit cc);
        m_z = 1'b0; m_err = 1'b0;
        if (cl) begin
            if (clen >= 1 && clen <= ML) begin
                m_pat = cp; m_len = clen; m_ov = cov; m_fill = 0; m_hist.delete();
            end else begin
                m_err = 1'b1;
            end
        end else if (v) begin
            m_hist.push_back(xb);
            if (m_hist.size() > ML) void'(m_hist.pop_front());
            m_fill = (m_fill + 1 > m_len) ? m_len : m_fill + 1;
            if (m_fill == m_len && tail_match()) begin
                m_z = 1'b1;
                if (!m_ov) m_fill = 0;
            end
        end
        if (cc) m_cnt = m_z ? 1 : 0;
        else if (m_z && m_cnt < CNT_MAX) m_cnt++;
        m_state = m_z ? 2 : ((m_fill == m_len) ? 1 : 0);
    endtask

    task automatic check_all();
        check("z", z, m_z);
        check("state", state, m_state);
        check("fill", fill, m_fill);
        check("count", match_count, m_cnt);
        check("cfg_err", cfg_err, m_err);
    endtask

    // Called at posedge+1: drive, clock, update model, check.
    task automatic step(input bit v, input bit xb, input bit cl, input bit [ML-1:0] cp,
                        input int clen, input bit cov, input bit cc);
        in_valid = v; x = xb; cfg_load = cl; cfg_pattern = cp;
        cfg_len = 4'(clen); cfg_overlap = cov; cnt_clr = cc;
        @(posedge clk);
        model_step(v, xb, cl, cp, clen, cov, cc);
        #1;
        check_all();
        in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic bit_in(input bit b);  step(1'b1, b, 1'b0, '0, 0, 1'b0, 1'b0); endtask
    task automatic idle();               step(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0); endtask
    task automatic clr();                step(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1); endtask
    task automatic cfg(input bit [ML-1:0] p, input int l, input bit o);
        step(1'b0, 1'b0, 1'b1, p, l, o, 1'b0);
    endtask

    task automatic send(input bit [ML-1:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #2;
        phase = "reset";
        do_reset();

        phase = "default";
        send(8'b010110, 6);
        check("hit_state", state, 2);
        check("hit_cnt", match_count, 1);
        idle();
        check("armed_after", state, 1);

        phase = "ovl1";
        clr();
        cfg(8'b101, 3, 1'b1);
        send(8'b10101, 5);
        check("ovl_cnt", match_count, 2);

        phase = "ovl0";
        clr();
        cfg(8'b101, 3, 1'b0);
        send(8'b10101, 5);
        check("novl_cnt", match_count, 1);

        phase = "gap";
        clr();
        cfg(8'b010110, 6, 1'b1);
        send(8'b01, 2);
        repeat (3) begin
            idle();
            check("gap_fill", fill, 2);
        end
        send(8'b0110, 4);
        check("gap_cnt", match_count, 1);

        phase = "len0";
        cfg(8'hAA, 0, 1'b0);
        check("len0_err", cfg_err, 1);
        idle();
        check("len0_err_drop", cfg_err, 0);
        send(8'b010110, 6);
        check("len0_still_hit", z, 1);

        phase = "len9";
        cfg(8'h01, 9, 1'b0);
        send(8'b010110, 6);

        phase = "lenmax";
        cfg(8'hFF, 8, 1'b1);
        for (int i = 0; i < 7; i++) begin
            bit_in(1'b1);
            check("max_nohit", z, 0);
        end
        bit_in(1'b1);
        check("max_hit", z, 1);

        phase = "cfg_vs_bit";
        bit_in(1'b1);
        step(1'b1, 1'b1, 1'b1, 8'b11, 2, 1'b1, 1'b0);
        check("coinc_fill", fill, 0);

        phase = "sat";
        cfg(8'b1, 1, 1'b1);
        clr();
        for (int i = 0; i < 5; i++) begin
            bit_in(1'b1);
            check("sat_cnt", match_count, (i < 3) ? i + 1 : 3);
        end
        step(1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b1);
        check("clr_hit", match_count, 1);
        cfg(8'b1, 1, 1'b0);
        bit_in(1'b1);
        bit_in(1'b0);

        phase = "midreset";
        do_reset();
        send(8'b01011, 5);
        reset = 1'b0;
        model_reset();
        #1;
        check("mid_z", z, 0);
        check("mid_fill", fill, 0);
        check("mid_state", state, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        bit_in(1'b0);
        check("mid_tail_only", z, 0);
        send(8'b010110, 6);
        check("mid_full", z, 1);

        phase = "async_z";
        reset = 1'b0;
        model_reset();
        #1;
        check("async_z_drop", z, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        phase = "random";
        for (int n = 0; n < 3000; n++) begin
            int r = $urandom_range(0, 99);
            if (r < 3) begin
                int l = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 3) : $urandom_range(0, 9);
                bit ok = (l >= 1 && l <= ML);
                step(ok ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)), 1'b1,
                     8'($urandom), l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
            end else begin
                step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'b0, '0, 0, 1'b0,
                     $urandom_range(0, 49) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
